// File: rtl/metronome_sequencer.sv
// Metronome tempo/bar scheduler: run/stop, BPM and meter settings, phase-accumulator
// beat timing, accented speaker beep and beat LEDs. All outputs are registered.
module metronome_sequencer #(
  parameter int unsigned FREQ          = 24_000_000,
  parameter int unsigned BPM_MIN       = 40,
  parameter int unsigned BPM_MAX       = 240,
  parameter int unsigned BPM_DEFAULT   = 90,
  parameter int unsigned BPM_STEP      = 5,
  parameter int unsigned BEATS_DEFAULT = 4,
  parameter int unsigned BEEP_CYCLES   = 60_000,
  parameter int unsigned ACCENT_CYCLES = 120_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start_stop_pressed,
  input  logic       inc_pressed,
  input  logic       dec_pressed,
  input  logic       meter_pressed,
  output logic       speaker,
  output logic [2:0] led,
  output logic       beat_strobe,
  output logic       accent,
  output logic [2:0] beat_idx,
  output logic [7:0] bpm,
  output logic [3:0] beats_per_bar,
  output logic       running
);

  localparam logic [30:0] LIMIT    = 31'(FREQ * 60);
  localparam int unsigned BEEP_MAX = (ACCENT_CYCLES > BEEP_CYCLES) ? ACCENT_CYCLES : BEEP_CYCLES;
  localparam int          CW       = $clog2(BEEP_MAX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [30:0]     acc, acc_nxt;
  logic [31:0]     acc_sum;
  logic [CW-1:0]   beep_cnt, beep_nxt;
  logic [7:0]      bpm_nxt;
  logic [3:0]      bpb_nxt, idx_inc;
  logic [2:0]      idx_nxt, led_nxt;
  logic            beat, accent_nxt, speaker_nxt;

  always_comb begin
    state_nxt = state;
    if (start_stop_pressed) state_nxt = (state == IDLE) ? RUN : IDLE;

    bpm_nxt = bpm;
    if (inc_pressed && !dec_pressed)
      bpm_nxt = (bpm >= 8'(BPM_MAX - BPM_STEP)) ? 8'(BPM_MAX) : bpm + 8'(BPM_STEP);
    else if (dec_pressed && !inc_pressed)
      bpm_nxt = (bpm <= 8'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm - 8'(BPM_STEP);

    bpb_nxt = beats_per_bar;
    if (meter_pressed) bpb_nxt = (beats_per_bar >= 4'd8) ? 4'd1 : beats_per_bar + 4'd1;

    // 32-bit sum: acc < LIMIT < 2^31 and bpm < 2^8, so this never overflows
    acc_sum = {1'b0, acc} + 32'(bpm);
    idx_inc = {1'b0, beat_idx} + 4'd1;
    acc_nxt = acc;
    idx_nxt = beat_idx;
    beat    = 1'b0;
    if (state == IDLE) begin
      acc_nxt = '0;
      idx_nxt = '0;
      beat    = (state_nxt == RUN);   // first beat strobes right after the start press
    end else if (state_nxt == IDLE) begin
      acc_nxt = '0;
      idx_nxt = '0;
    end else if (acc_sum >= {1'b0, LIMIT}) begin
      acc_nxt = 31'(acc_sum - {1'b0, LIMIT});
      beat    = 1'b1;
      idx_nxt = (idx_inc >= beats_per_bar) ? 3'd0 : idx_inc[2:0];
    end else begin
      acc_nxt = acc_sum[30:0];
    end
    accent_nxt = beat && (idx_nxt == 3'd0);

    // a new beat reloads the counter even mid-beep, so retriggers leave no gap
    beep_nxt = '0;
    if (state_nxt == RUN) begin
      if (beat)                beep_nxt = accent_nxt ? CW'(ACCENT_CYCLES) : CW'(BEEP_CYCLES);
      else if (beep_cnt != '0) beep_nxt = beep_cnt - 1'b1;
    end
    speaker_nxt = (beep_nxt == '0);
    led_nxt     = (state_nxt == RUN) ? ~idx_nxt : 3'b111;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      beep_cnt      <= '0;
      bpm           <= 8'(BPM_DEFAULT);
      beats_per_bar <= 4'(BEATS_DEFAULT);
      beat_idx      <= '0;
      speaker       <= 1'b1;
      led           <= 3'b111;
      beat_strobe   <= 1'b0;
      accent        <= 1'b0;
      running       <= 1'b0;
    end else begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      beep_cnt      <= beep_nxt;
      bpm           <= bpm_nxt;
      beats_per_bar <= bpb_nxt;
      beat_idx      <= idx_nxt;
      speaker       <= speaker_nxt;
      led           <= led_nxt;
      beat_strobe   <= beat;
      accent        <= accent_nxt;
      running       <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_metronome_sequencer.sv
// Bench for metronome_sequencer: settings table, beat scoreboard, multi-cycle
// sequences for tempo change, meter shrink, stop, reset mid-beep and retrigger.
module tb_metronome_sequencer;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic ss, inc, dec, meter;
  logic speaker, beat_strobe, accent, running;
  logic [2:0] led, beat_idx;
  logic [7:0] bpm;
  logic [3:0] bpb;

  logic r_ss, r_zero;
  logic r_speaker, r_strobe, r_accent, r_running;
  logic [2:0] r_led, r_idx;
  logic [7:0] r_bpm;
  logic [3:0] r_bpb;

  always #5 sys_clk = ~sys_clk;

  metronome_sequencer #(.FREQ(100), .BEEP_CYCLES(10), .ACCENT_CYCLES(20)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_stop_pressed(ss),
    .inc_pressed(inc), .dec_pressed(dec), .meter_pressed(meter),
    .speaker(speaker), .led(led), .beat_strobe(beat_strobe), .accent(accent),
    .beat_idx(beat_idx), .bpm(bpm), .beats_per_bar(bpb), .running(running));

  // second instance: long normal beep so consecutive beats overlap
  metronome_sequencer #(.FREQ(100), .BPM_DEFAULT(60), .BEEP_CYCLES(200), .ACCENT_CYCLES(20)) dut_rt (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_stop_pressed(r_ss),
    .inc_pressed(r_zero), .dec_pressed(r_zero), .meter_pressed(r_zero),
    .speaker(r_speaker), .led(r_led), .beat_strobe(r_strobe), .accent(r_accent),
    .beat_idx(r_idx), .bpm(r_bpm), .beats_per_bar(r_bpb), .running(r_running));

  typedef struct { int at; int idx; bit acc; } beat_t;
  typedef struct { bit inc; bit dec; bit meter; int bpm; int bpb; } vec_t;

  beat_t sb[$];
  beat_t mon_e;
  int    lens[$];
  int    low_run = 0;
  int    cyc = 0;
  int    checks = 0, errors = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  // beat scoreboard for the main instance
  always @(negedge sys_clk) begin
    if (beat_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: cycle %0d idx %0d, expected no beat", cyc, beat_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_cycle", cyc, mon_e.at);
        chk("beat_idx", beat_idx, mon_e.idx);
        chk("beat_accent", accent, 32'(mon_e.acc));
        chk("beat_led", led, {29'd0, ~3'(mon_e.idx)});
        chk("beat_speaker", speaker, 0);
      end
    end else if (accent === 1'b1) begin
      checks++; errors++;
      $display("FAIL stray_accent: cycle %0d accent high without strobe", cyc);
    end
  end

  always @(negedge sys_clk) begin
    if (speaker === 1'b0) low_run++;
    else if (low_run > 0) begin
      lens.push_back(low_run);
      low_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int   exp_lens[5];
    int   p, hi;

    tbl[0]  = '{1, 0, 0, 95, 4};
    tbl[1]  = '{0, 1, 0, 90, 4};
    tbl[2]  = '{1, 1, 0, 90, 4};
    tbl[3]  = '{0, 1, 0, 85, 4};
    tbl[4]  = '{0, 0, 1, 85, 5};
    tbl[5]  = '{0, 0, 1, 85, 6};
    tbl[6]  = '{0, 0, 1, 85, 7};
    tbl[7]  = '{0, 0, 1, 85, 8};
    tbl[8]  = '{0, 0, 1, 85, 1};
    tbl[9]  = '{1, 0, 1, 90, 2};
    tbl[10] = '{0, 0, 1, 90, 3};
    tbl[11] = '{0, 0, 1, 90, 4};
    exp_lens = '{20, 10, 10, 10, 20};

    ss = 0; inc = 0; dec = 0; meter = 0; r_ss = 0; r_zero = 0;
    sys_rst_n = 0;
    tick(2);
    sys_rst_n = 1;

    chk("rst_speaker", speaker, 1);
    chk("rst_led", led, 3'b111);
    chk("rst_strobe", beat_strobe, 0);
    chk("rst_accent", accent, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_bpm", bpm, 90);
    chk("rst_bpb", bpb, 4);
    chk("rst_running", running, 0);
    chk("rst_rt_bpm", r_bpm, 60);

    // settings table (IDLE)
    foreach (tbl[i]) begin
      inc = tbl[i].inc; dec = tbl[i].dec; meter = tbl[i].meter;
      tick();
      inc = 0; dec = 0; meter = 0;
      chk($sformatf("tbl%0d_bpm", i), bpm, tbl[i].bpm);
      chk($sformatf("tbl%0d_bpb", i), bpb, tbl[i].bpb);
    end

    // saturation
    inc = 1; tick(40); inc = 0;
    chk("sat_max", bpm, 240);
    inc = 1; dec = 1; tick(); inc = 0; dec = 0;
    chk("sat_incdec", bpm, 240);
    dec = 1; tick(60); dec = 0;
    chk("sat_min", bpm, 40);
    inc = 1; tick(4); inc = 0;
    chk("set_60", bpm, 60);

    // basic timing at 60 bpm: period 100
    lens.delete();
    p = cyc + 1;
    sb.push_back('{p,       0, 1});
    sb.push_back('{p + 100, 1, 0});
    sb.push_back('{p + 200, 2, 0});
    sb.push_back('{p + 300, 3, 0});
    sb.push_back('{p + 400, 0, 1});
    ss = 1; tick(); ss = 0;
    chk("run_on", running, 1);
    wait_cyc(p + 430);
    ss = 1; tick(); ss = 0;
    chk("stop1_running", running, 0);
    chk("stop1_led", led, 3'b111);
    chk("basic_sb_drained", sb.size(), 0);
    chk("beep_count", lens.size(), 5);
    foreach (exp_lens[i])
      if (i < lens.size()) chk($sformatf("beep_len%0d", i), lens[i], exp_lens[i]);

    // tempo ramp 60->120 mid-beat (acc 1980 + 1050 during ramp = 3030), then meter shrink
    p = cyc + 1;
    sb.push_back('{p,       0, 1});
    sb.push_back('{p + 70,  1, 0});
    sb.push_back('{p + 120, 2, 0});
    sb.push_back('{p + 170, 3, 0});
    sb.push_back('{p + 220, 0, 1});
    sb.push_back('{p + 270, 0, 1});
    sb.push_back('{p + 320, 0, 1});
    ss = 1; tick(); ss = 0;
    wait_cyc(p + 33);
    inc = 1; tick(12); inc = 0;
    chk("ramp_bpm", bpm, 120);
    wait_cyc(p + 175);
    meter = 1; tick(5); meter = 0;
    chk("shrink_bpb", bpb, 1);
    chk("shrink_idx_kept", beat_idx, 3);
    wait_cyc(p + 325);
    chk("beep_before_stop", speaker, 0);
    ss = 1; tick(); ss = 0;
    chk("stop2_running", running, 0);
    chk("stop2_speaker", speaker, 1);
    chk("stop2_led", led, 3'b111);
    chk("stop2_idx", beat_idx, 0);
    chk("tempo_sb_drained", sb.size(), 0);

    // restart, then reset mid-beep
    sb.push_back('{cyc + 1, 0, 1});
    ss = 1; tick(); ss = 0;
    tick(5);
    chk("pre_reset_beep", speaker, 0);
    sys_rst_n = 0; tick(); sys_rst_n = 1;
    chk("mid_rst_speaker", speaker, 1);
    chk("mid_rst_led", led, 3'b111);
    chk("mid_rst_strobe", beat_strobe, 0);
    chk("mid_rst_accent", accent, 0);
    chk("mid_rst_idx", beat_idx, 0);
    chk("mid_rst_bpm", bpm, 90);
    chk("mid_rst_bpb", bpb, 4);
    chk("mid_rst_running", running, 0);
    tick(120);
    chk("restart_sb_drained", sb.size(), 0);

    // retrigger: normal beeps (200) overlap every 100 cycles; accent reload shortens to 20
    p = cyc + 1;
    r_ss = 1; tick(); r_ss = 0;
    chk("rt_first_strobe", r_strobe, 1);
    chk("rt_first_accent", r_accent, 1);
    wait_cyc(p + 100);
    hi = 0;
    for (int k = 0; k < 320; k++) begin
      if (r_speaker !== 1'b0) hi++;
      tick();
    end
    chk("rt_continuous_low", hi, 0);
    chk("rt_accent_release", r_speaker, 1);
    chk("rt_idx_bar", r_idx, 0);
    wait_cyc(p + 430);
    r_ss = 1; tick(); r_ss = 0;
    chk("rt_stop_running", r_running, 0);
    chk("rt_stop_speaker", r_speaker, 1);
    chk("rt_stop_led", r_led, 3'b111);
    tick(3);
    r_ss = 1; tick(); r_ss = 0;
    chk("rt_restart_strobe", r_strobe, 1);
    chk("rt_restart_accent", r_accent, 1);
    chk("rt_restart_idx", r_idx, 0);
    chk("rt_restart_speaker", r_speaker, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
